load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-access stage of an in-order core. It takes one load or store from
//   the execute stage and issues a single word-aligned request to the data
//   memory. Stores retire when the memory answers. Loads pass through one
//   write-back cycle that carries the extracted and extended data. Illegal or
//   misaligned ops, and ops the memory never answers, raise err for one cycle.
//
//   Ports
//     clk, rst_n                  clock, asynchronous active-low reset
//     valid, is_load, is_store    op handshake from execute (load wins if both)
//     funct3, addr, wdata, rd     op width/sign, byte address, store data, dest
//     mem_req, mem_we, mem_addr,
//     mem_wdata, mem_wstrb        memory request, held stable during ACCESS
//     mem_ready, mem_rdata        memory response, looked at only in ACCESS
//     stall                       holds execute while an op is being taken/served
//     wb_valid, wb_rd, wb_data    load write-back, one cycle
//     err                         one-cycle pulse: illegal op or timeout
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for an op; an illegal op only pulses err
//   ACCESS | mem_req high; wait for mem_ready or the timeout count
//   DONE   | load data on wb_*, wb_valid high for this single cycle
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;
    logic        r_mem_we;
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] r_wb_data;
    logic        r_err;

    logic        w_op;
    logic        w_illegal;
    logic        w_accept;
    logic        w_timeout;
    logic [7:0]  w_cnt_inc;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;

    assign w_op      = valid & (is_load | is_store);
    assign w_accept  = (r_state == IDLE) & w_op & ~w_illegal;
    assign w_cnt_inc = r_cnt + 8'd1;
    // mem_ready in the final counted cycle still completes the access.
    assign w_timeout = (r_state == ACCESS) & ~mem_ready & (w_cnt_inc == TIMEOUT_CNT);

    // is_load takes priority, so a "both high" op is checked as a load.
    always_comb begin
        w_illegal = 1'b0;
        if (is_load) begin
            if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                w_illegal = 1'b1;
        end else if (funct3 >= 3'b011) begin
            w_illegal = 1'b1;
        end
        if (funct3[1:0] == 2'b01 && addr[0])
            w_illegal = 1'b1;
        if (funct3 == 3'b010 && addr[1:0] != 2'b00)
            w_illegal = 1'b1;
    end

    // Store lanes: data is replicated so the strobes alone pick the bytes.
    always_comb begin
        w_strb  = 4'b0000;
        w_wdata = wdata;
        if (!is_load) begin
            case (funct3[1:0])
                2'b00: begin
                    w_strb  = 4'b0001 << addr[1:0];
                    w_wdata = {4{wdata[7:0]}};
                end
                2'b01: begin
                    w_strb  = addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{wdata[15:0]}};
                end
                default: w_strb = 4'b1111;
            endcase
        end
    end

    always_comb begin
        case (r_off)
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            2'd3:    w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_data = {24'd0, w_byte};
            3'b101:  w_ld_data = {16'd0, w_half};
            default: w_ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept)
                    w_next = ACCESS;
            end
            ACCESS: begin
                if (mem_ready)
                    w_next = r_mem_we ? IDLE : DONE;
                else if (w_timeout)
                    w_next = IDLE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // stall is gated by rst_n so it reads 0 while reset is held even if an
    // op is being presented.
    always_comb begin
        mem_req  = (r_state == ACCESS);
        wb_valid = (r_state == DONE);
        stall    = rst_n & (((r_state == IDLE) & w_accept) | (r_state == ACCESS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 8'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_wstrb <= 4'd0;
            r_mem_we    <= 1'b0;
            r_rd        <= 5'd0;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_wb_data   <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            r_err <= ((r_state == IDLE) & w_op & w_illegal) | w_timeout;
            if (w_accept) begin
                r_cnt       <= 8'd0;
                r_mem_addr  <= {addr[31:2], 2'b00};
                r_mem_wdata <= w_wdata;
                r_mem_wstrb <= w_strb;
                r_mem_we    <= ~is_load;
                r_rd        <= rd;
                r_funct3    <= funct3;
                r_off       <= addr[1:0];
            end else if (r_state == ACCESS && !mem_ready) begin
                r_cnt <= w_cnt_inc;
            end
            if (r_state == ACCESS && mem_ready && !r_mem_we)
                r_wb_data <= w_ld_data;
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign mem_we    = r_mem_we;
    assign wb_rd     = r_rd;
    assign wb_data   = r_wb_data;
    assign err       = r_err;

endmodule
